// File: rtl/seq_pkg.sv
// Shared widths and types for the 16-bit sequence splitter / aligner pair.
package seq_pkg;
  localparam int SEQ_W   = 16;
  localparam int CHUNK_W = 7;
  localparam int NUM_W   = 3;
  localparam int LVL_W   = 6;
  localparam int BUF_W   = 2 * SEQ_W;

  typedef logic [NUM_W-1:0]   num_t;
  typedef logic [LVL_W-1:0]   lvl_t;
  typedef logic [BUF_W-1:0]   buf_t;
  typedef logic [CHUNK_W-1:0] chunk_t;

  typedef struct packed {
    chunk_t seq;
    num_t   num;
  } out_t;

  // When cnt < req the request cannot be met in full; only possible for cnt < 8,
  // so narrowing cnt to num_t is lossless there.
  function automatic num_t grant(num_t req, lvl_t cnt, bit partial);
    if (cnt >= lvl_t'(req)) return req;
    return partial ? num_t'(cnt) : '0;
  endfunction
endpackage

// File: rtl/sequence_splitter_if.sv
// Word-in / chunk-out handshake bundle of the sequence splitter.
interface sequence_splitter_if import seq_pkg::*; ();
  logic [SEQ_W-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  num_t             req_num;
  chunk_t           out_seq;
  num_t             out_num;
  logic             out_valid;
  lvl_t             level;

  modport master (output in_word, in_valid, req_num,
                  input  in_ready, out_seq, out_num, out_valid, level);
  modport slave  (input  in_word, in_valid, req_num,
                  output in_ready, out_seq, out_num, out_valid, level);
endinterface

// File: rtl/seq_chunk_extract.sv
// Pops the top g bits of an MSB-aligned buffer: right-aligned chunk plus the shifted remainder.
module seq_chunk_extract import seq_pkg::*; (
  input  buf_t   bits_i,
  input  num_t   g_i,
  output chunk_t chunk_o,
  output buf_t   shifted_o
);
  buf_t tail;

  // g=0 shifts by the full width, which yields an all-zero chunk.
  assign tail      = bits_i >> (BUF_W - int'(g_i));
  assign chunk_o   = tail[CHUNK_W-1:0];
  assign shifted_o = bits_i << g_i;
endmodule

// File: rtl/sequence_splitter.sv
// Serializes 16-bit words MSB-first into 0..7-bit chunks sized by a per-cycle request.
module sequence_splitter import seq_pkg::*; #(
  parameter bit ALLOW_PARTIAL = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  sequence_splitter_if.slave sp
);
  buf_t   bits_q, bits_d, shifted;
  lvl_t   cnt_q, cnt_d;
  out_t   out_q, out_d;
  logic   vld_q, vld_d;
  num_t   g;
  chunk_t chunk;
  logic   load;

  // Ready looks only at registered state, so the upstream never sees a req_num path.
  assign sp.in_ready = (cnt_q <= lvl_t'(SEQ_W));
  assign load        = sp.in_valid && sp.in_ready;
  assign g           = grant(sp.req_num, cnt_q, ALLOW_PARTIAL);

  seq_chunk_extract u_extract (
    .bits_i    (bits_q),
    .g_i       (g),
    .chunk_o   (chunk),
    .shifted_o (shifted)
  );

  always_comb begin
    bits_d = shifted;
    cnt_d  = cnt_q - lvl_t'(g);
    // New word lands directly behind whatever survives this cycle's drain.
    if (load) begin
      bits_d = shifted | (buf_t'({sp.in_word, {SEQ_W{1'b0}}}) >> (cnt_q - lvl_t'(g)));
      cnt_d  = cnt_d + lvl_t'(SEQ_W);
    end
    out_d.seq = chunk;
    out_d.num = g;
    vld_d     = (g != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
    end
  end

  assign sp.out_seq   = out_q.seq;
  assign sp.out_num   = out_q.num;
  assign sp.out_valid = vld_q;
  assign sp.level     = cnt_q;
endmodule

// File: tb/tb_sequence_splitter.sv
// Directed bench: partial-grant splitter plus a strict-mode instance on a shared clock.
module tb_sequence_splitter;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sequence_splitter_if pif ();
  sequence_splitter_if sif ();

  sequence_splitter #(.ALLOW_PARTIAL(1'b1)) dut_p (.clk(clk), .rst_n(rst_n), .sp(pif.slave));
  sequence_splitter #(.ALLOW_PARTIAL(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .sp(sif.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_p(input logic v, input logic [15:0] w, input logic [2:0] r);
    pif.in_valid = v; pif.in_word = w; pif.req_num = r;
  endtask

  task automatic chk_out(input string tag, input logic [6:0] seq, input logic [2:0] num, input logic [5:0] lvl);
    chk({tag, ".seq"}, 32'(pif.out_seq), 32'(seq));
    chk({tag, ".num"}, 32'(pif.out_num), 32'(num));
    chk({tag, ".vld"}, 32'(pif.out_valid), 32'(num != 3'd0));
    chk({tag, ".lvl"}, 32'(pif.level), 32'(lvl));
  endtask

  initial begin
    drv_p(1'b0, 16'h0, 3'd0);
    sif.in_valid = 1'b0; sif.in_word = '0; sif.req_num = '0;
    #12;
    chk("rst_ready", 32'(pif.in_ready), 32'd1);
    chk_out("rst", 7'h00, 3'd0, 6'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;

    // Empty buffer with nonzero request grants nothing
    drv_p(1'b0, 16'h0, 3'd7); step();
    chk_out("empty_req", 7'h00, 3'd0, 6'd0);

    // 1: round trip of FF0F
    drv_p(1'b1, 16'hFF0F, 3'd0); step();
    chk_out("rt_load", 7'h00, 3'd0, 6'd16);
    drv_p(1'b0, 16'h0, 3'd7); step(); chk_out("rt_c0", 7'h7F, 3'd7, 6'd9);
    step();                          chk_out("rt_c1", 7'h43, 3'd7, 6'd2);
    drv_p(1'b0, 16'h0, 3'd2); step(); chk_out("rt_c2", 7'h03, 3'd2, 6'd0);
    drv_p(1'b0, 16'h0, 3'd0); step(); chk_out("rt_idle", 7'h00, 3'd0, 6'd0);

    // 2: partial grant with req held at 7; load cycle itself grants nothing
    drv_p(1'b1, 16'hA5A5, 3'd7); step(); chk_out("pg_load", 7'h00, 3'd0, 6'd16);
    drv_p(1'b0, 16'h0, 3'd7);   step(); chk_out("pg_c0", 7'h52, 3'd7, 6'd9);
    step();                             chk_out("pg_c1", 7'h69, 3'd7, 6'd2);
    step();                             chk_out("pg_c2", 7'h01, 3'd2, 6'd0);
    step();                             chk_out("pg_c3", 7'h00, 3'd0, 6'd0);

    // 3: backpressure
    drv_p(1'b1, 16'h1234, 3'd0); step(); chk_out("bp_w0", 7'h00, 3'd0, 6'd16);
    chk("bp_rdy16", 32'(pif.in_ready), 32'd1);
    drv_p(1'b1, 16'h5678, 3'd0); step(); chk_out("bp_w1", 7'h00, 3'd0, 6'd32);
    chk("bp_rdy32", 32'(pif.in_ready), 32'd0);
    drv_p(1'b1, 16'h9ABC, 3'd0); step(); chk_out("bp_hold", 7'h00, 3'd0, 6'd32);
    drv_p(1'b1, 16'h9ABC, 3'd7); step(); chk_out("bp_d0", 7'h09, 3'd7, 6'd25);
    step();                              chk_out("bp_d1", 7'h0D, 3'd7, 6'd18);
    chk("bp_rdy18", 32'(pif.in_ready), 32'd0);
    drv_p(1'b1, 16'h9ABC, 3'd2); step(); chk_out("bp_d2", 7'h00, 3'd2, 6'd16);
    chk("bp_rdy16b", 32'(pif.in_ready), 32'd1);
    drv_p(1'b1, 16'h9ABC, 3'd0); step(); chk_out("bp_w2", 7'h00, 3'd0, 6'd32);
    drv_p(1'b0, 16'h0, 3'd7); step(); chk_out("bp_e0", 7'h2B, 3'd7, 6'd25);
    step();                          chk_out("bp_e1", 7'h1E, 3'd7, 6'd18);
    drv_p(1'b0, 16'h0, 3'd2); step(); chk_out("bp_e2", 7'h00, 3'd2, 6'd16);
    drv_p(1'b0, 16'h0, 3'd7); step(); chk_out("bp_e3", 7'h4D, 3'd7, 6'd9);
    step();                          chk_out("bp_e4", 7'h2F, 3'd7, 6'd2);
    drv_p(1'b0, 16'h0, 3'd2); step(); chk_out("bp_e5", 7'h00, 3'd2, 6'd0);

    // 5: simultaneous load and drain
    drv_p(1'b1, 16'h00FF, 3'd0); step(); chk_out("sd_load", 7'h00, 3'd0, 6'd16);
    drv_p(1'b0, 16'h0, 3'd7);   step(); chk_out("sd_c0", 7'h00, 3'd7, 6'd9);
    drv_p(1'b1, 16'hC003, 3'd7); step(); chk_out("sd_both", 7'h3F, 3'd7, 6'd18);
    drv_p(1'b0, 16'h0, 3'd2);   step(); chk_out("sd_old", 7'h03, 3'd2, 6'd16);
    drv_p(1'b0, 16'h0, 3'd7);   step(); chk_out("sd_n0", 7'h60, 3'd7, 6'd9);
    step();                             chk_out("sd_n1", 7'h00, 3'd7, 6'd2);
    drv_p(1'b0, 16'h0, 3'd2);   step(); chk_out("sd_n2", 7'h03, 3'd2, 6'd0);

    // 4: strict mode on the second instance
    sif.in_valid = 1'b1; sif.in_word = 16'hA5A5; sif.req_num = 3'd0; step();
    sif.in_valid = 1'b0; sif.req_num = 3'd7; step();
    chk("st_c0", 32'(sif.out_seq), 32'h52);
    step();
    chk("st_c1", 32'(sif.out_seq), 32'h69);
    chk("st_lvl2", 32'(sif.level), 32'd2);
    step();
    chk("st_deny_vld", 32'(sif.out_valid), 32'd0);
    chk("st_deny_num", 32'(sif.out_num), 32'd0);
    chk("st_deny_lvl", 32'(sif.level), 32'd2);
    sif.req_num = 3'd2; step();
    chk("st_c2_seq", 32'(sif.out_seq), 32'h01);
    chk("st_c2_num", 32'(sif.out_num), 32'd2);
    chk("st_c2_lvl", 32'(sif.level), 32'd0);
    sif.req_num = 3'd0;

    // 6: asynchronous reset mid-stream
    drv_p(1'b1, 16'hFFFF, 3'd0); step();
    drv_p(1'b0, 16'h0, 3'd3);   step(); chk_out("ar_pre", 7'h07, 3'd3, 6'd13);
    #2 rst_n = 1'b0;
    #1;
    chk_out("ar_now", 7'h00, 3'd0, 6'd0);
    chk("ar_rdy", 32'(pif.in_ready), 32'd1);
    drv_p(1'b0, 16'h0, 3'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    drv_p(1'b1, 16'hB00B, 3'd0); step(); chk_out("ar_load", 7'h00, 3'd0, 6'd16);
    drv_p(1'b0, 16'h0, 3'd7);   step(); chk_out("ar_c0", 7'h58, 3'd7, 6'd9);
    step();                             chk_out("ar_c1", 7'h02, 3'd7, 6'd2);
    drv_p(1'b0, 16'h0, 3'd2);   step(); chk_out("ar_c2", 7'h03, 3'd2, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
